video_timing_ctrl: RTL and testbench

//  Raster sequencer for the HDMI output path. Generates the scan coordinates sx/sy that

---
 rtl/video_timing_ctrl.sv | 136 +++++++++++++
 tb/tb_video_timing_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_ctrl.sv
// Raster sequencer: scan coordinates for the painter plus sync/de delayed to match
// the painter's registered RGB. Start/stop takes effect on frame boundaries only.
module video_timing_ctrl #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit SYNC_POL = 1'b1,
    parameter int SYNC_DLY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [10:0] sx,
    output logic [10:0] sy,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o,
    output logic        line_start,
    output logic        frame_start,
    output logic        running,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int NST     = SYNC_DLY + 1;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (SYNC_DLY < 0 || SYNC_DLY > 4) begin : g_bad_dly
            $error("video_timing_ctrl: SYNC_DLY must be 0..4");
        end
        if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_total
            $error("video_timing_ctrl: line/frame totals must fit 11 bits");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_t;

    state_t      state, state_nxt;
    logic [10:0] sx_nxt, sy_nxt;
    logic [15:0] fc_nxt;
    logic        last_px, run_nxt, ls_nxt, fs_nxt;
    logic [2:0]  raw_nxt;              // {vs, hs, de}, active-high internally
    logic [2:0]  stg_p [NST];          // stg_p[0] lines up with sx/sy
    logic        hs_l, vs_l, de_l;

    assign last_px = (sx == H_LAST) && (sy == V_LAST);

    always_comb begin
        state_nxt = state;
        sx_nxt    = sx;
        sy_nxt    = sy;
        fc_nxt    = frame_cnt;
        case (state)
            IDLE:      if (en) state_nxt = RUN;
            RUN:       if (!en) state_nxt = STOP_PEND;
            STOP_PEND: begin
                if (en)           state_nxt = RUN;
                else if (last_px) state_nxt = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
        if (state != IDLE) begin
            if (sx == H_LAST) begin
                sx_nxt = 11'd0;
                if (sy == V_LAST) begin
                    sy_nxt = 11'd0;
                    fc_nxt = frame_cnt + 16'd1;
                end else begin
                    sy_nxt = sy + 11'd1;
                end
            end else begin
                sx_nxt = sx + 11'd1;
            end
        end
    end

    // Raw timing is derived from the next coordinates so it registers alongside sx/sy.
    assign run_nxt    = (state_nxt != IDLE);
    assign raw_nxt[0] = run_nxt && (sx_nxt < H_ACT) && (sy_nxt < V_ACT);
    assign raw_nxt[1] = run_nxt && (sx_nxt >= HS_BEG) && (sx_nxt < HS_END);
    assign raw_nxt[2] = run_nxt && (sy_nxt >= VS_BEG) && (sy_nxt < VS_END);
    assign ls_nxt     = run_nxt && (sx_nxt == 11'd0);
    assign fs_nxt     = ls_nxt && (sy_nxt == 11'd0);

    // Stage p0: state, counters, pulses and raw timing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sx          <= 11'd0;
            sy          <= 11'd0;
            frame_cnt   <= 16'd0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            state       <= state_nxt;
            sx          <= sx_nxt;
            sy          <= sy_nxt;
            frame_cnt   <= fc_nxt;
            line_start  <= ls_nxt;
            frame_start <= fs_nxt;
            running     <= run_nxt;
        end
    end

    // Stages p1..pSYNC_DLY: delay line keeps shifting in IDLE so a stop drains out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NST; i++) stg_p[i] <= 3'b000;
        end else begin
            stg_p[0] <= raw_nxt;
            for (int i = 1; i < NST; i++) stg_p[i] <= stg_p[i-1];
        end
    end

    assign {vs_l, hs_l, de_l} = stg_p[NST-1];
    assign de_o    = de_l;
    assign hsync_o = SYNC_POL ? hs_l : ~hs_l;
    assign vsync_o = SYNC_POL ? vs_l : ~vs_l;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl: reduced raster geometry, three sync polarity/delay builds,
// pixel-index reference model compared every cycle plus directed literal expectations.
module tb_video_timing_ctrl;

    localparam int HA = 16, HF = 4, HS = 3, HB = 5;
    localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;   // 28
    localparam int VT = VA + VF + VS + VB;   // 13
    localparam int FT = HT * VT;             // 364

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;

    logic [10:0] sx_a, sy_a, sx_b, sy_b, sx_c, sy_c;
    logic        hs_a, vs_a, de_a, ls_a, fs_a, run_a;
    logic        hs_b, vs_b, de_b, ls_b, fs_b, run_b;
    logic        hs_c, vs_c, de_c, ls_c, fs_c, run_c;
    logic [15:0] fc_a, fc_b, fc_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    video_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1), .SYNC_DLY(1)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .sx(sx_a), .sy(sy_a), .hsync_o(hs_a), .vsync_o(vs_a),
        .de_o(de_a), .line_start(ls_a), .frame_start(fs_a), .running(run_a), .frame_cnt(fc_a));

    video_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0), .SYNC_DLY(3)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .sx(sx_b), .sy(sy_b), .hsync_o(hs_b), .vsync_o(vs_b),
        .de_o(de_b), .line_start(ls_b), .frame_start(fs_b), .running(run_b), .frame_cnt(fc_b));

    video_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1), .SYNC_DLY(0)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .sx(sx_c), .sy(sy_c), .hsync_o(hs_c), .vsync_o(vs_c),
        .de_o(de_c), .line_start(ls_c), .frame_start(fs_c), .running(run_c), .frame_cnt(fc_c));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d, want %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: linear pixel index within the frame, a running flag and a
    // stop-requested flag; raw timing history indexed by delay in cycles.
    int       m_p = 0;
    int       m_fc = 0;
    bit       m_act = 1'b0;
    bit       m_pend = 1'b0;
    bit [2:0] m_hist [5];

    function automatic bit [2:0] raw_of(input int p);
        int x, y;
        bit d, h, v;
        x = p % HT;
        y = p / HT;
        d = (x < HA) && (y < VA);
        h = (x >= HA + HF) && (x < HA + HF + HS);
        v = (y >= VA + VF) && (y < VA + VF + VS);
        return {v, h, d};
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit last;
        if (!rst_n) begin
            m_p = 0; m_fc = 0; m_act = 1'b0; m_pend = 1'b0;
            for (int i = 0; i < 5; i++) m_hist[i] = 3'b000;
        end else begin
            last = m_act && (m_p == FT - 1);
            if (!m_act) begin
                m_act = en;
                m_pend = 1'b0;
                m_p = 0;
            end else begin
                m_p = (m_p + 1) % FT;
                if (last) m_fc = (m_fc + 1) % 65536;
                if (en) m_pend = 1'b0;
                else if (m_pend && last) m_act = 1'b0;
                else m_pend = 1'b1;
            end
            for (int i = 4; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = m_act ? raw_of(m_p) : 3'b000;
        end
    end

    task automatic cmp(input string t, input int dly, input bit pol,
                       input logic [10:0] x, input logic [10:0] y, input logic hs, input logic vs,
                       input logic de, input logic ls, input logic fs, input logic rn,
                       input logic [15:0] fc);
        bit [2:0] h;
        h = m_hist[dly];
        chk({t, ".sx"}, 32'(x), m_p % HT);
        chk({t, ".sy"}, 32'(y), m_p / HT);
        chk({t, ".de"}, 32'(de), int'(h[0]));
        chk({t, ".hsync"}, 32'(hs), int'(pol ? h[1] : !h[1]));
        chk({t, ".vsync"}, 32'(vs), int'(pol ? h[2] : !h[2]));
        chk({t, ".line_start"}, 32'(ls), int'(m_act && (m_p % HT == 0)));
        chk({t, ".frame_start"}, 32'(fs), int'(m_act && (m_p == 0)));
        chk({t, ".running"}, 32'(rn), int'(m_act));
        chk({t, ".frame_cnt"}, 32'(fc), m_fc);
    endtask

    always @(negedge clk) begin
        cmp("A", 1, 1'b1, sx_a, sy_a, hs_a, vs_a, de_a, ls_a, fs_a, run_a, fc_a);
        cmp("B", 3, 1'b0, sx_b, sy_b, hs_b, vs_b, de_b, ls_b, fs_b, run_b, fc_b);
        cmp("C", 0, 1'b1, sx_c, sy_c, hs_c, vs_c, de_c, ls_c, fs_c, run_c, fc_c);
    end

    task automatic wait_pos(input int x, input int y);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sx_a == 11'(x) && sy_a == 11'(y)) && n < 2 * FT + 4);
        chk("wait_pos", 32'(sx_a == 11'(x) && sy_a == 11'(y)), 1);
    endtask

    initial begin
        int n_de_a, n_de_b, n_hs_a, n_vs_a, n_ls, n;
        n_de_a = 0; n_de_b = 0; n_hs_a = 0; n_vs_a = 0; n_ls = 0; n = 0;

        repeat (3) @(negedge clk);
        chk("rst_sx", 32'(sx_a), 0);
        chk("rst_run", 32'(run_a), 0);
        chk("rst_hs_a", 32'(hs_a), 0);
        chk("rst_hs_b", 32'(hs_b), 1);
        chk("rst_fc", 32'(fc_a), 0);

        rst_n = 1'b1;
        en = 1'b1;
        @(negedge clk);
        chk("first_sx", 32'(sx_a), 0);
        chk("first_fs", 32'(fs_a), 1);
        chk("first_run", 32'(run_a), 1);

        for (int k = 0; k < 2 * FT; k++) begin
            n_de_a += int'(de_a);
            n_de_b += int'(de_b);
            n_hs_a += int'(hs_a);
            n_vs_a += int'(vs_a);
            n_ls   += int'(ls_a);
            if (k == HT - 1) chk("eol_sx", 32'(sx_a), HT - 1);
            if (k == HT) begin
                chk("wrap_sx", 32'(sx_a), 0);
                chk("wrap_sy", 32'(sy_a), 1);
                chk("wrap_ls", 32'(ls_a), 1);
            end
            @(negedge clk);
        end
        chk("two_frames_fc", 32'(fc_a), 2);
        chk("de_a_count", 32'(n_de_a), 192);
        chk("de_b_count", 32'(n_de_b), 192);
        chk("hs_a_count", 32'(n_hs_a), 78);
        chk("vs_a_count", 32'(n_vs_a), 112);
        chk("ls_count", 32'(n_ls), 26);

        // Stop mid-frame: frame completes, then idle.
        wait_pos(0, 3);
        en = 1'b0;
        while (run_a && n < 2 * FT) begin
            @(negedge clk);
            n++;
        end
        chk("stop_run", 32'(run_a), 0);
        chk("stop_fc", 32'(fc_a), 3);
        chk("stop_sx", 32'(sx_a), 0);
        repeat (3) @(negedge clk);
        chk("drain_hs_b", 32'(hs_b), 1);
        chk("drain_de_b", 32'(de_b), 0);

        // Stop then re-raise mid-frame: no gap.
        en = 1'b1;
        @(negedge clk);
        wait_pos(0, 3);
        en = 1'b0;
        wait_pos(0, 5);
        en = 1'b1;
        wait_pos(HT - 1, VT - 1);
        @(negedge clk);
        chk("rr_run", 32'(run_a), 1);
        chk("rr_sy", 32'(sy_a), 0);
        chk("rr_fs", 32'(fs_a), 1);

        // Re-raise on the very last pixel: RUN wins.
        wait_pos(0, 3);
        en = 1'b0;
        wait_pos(HT - 1, VT - 1);
        en = 1'b1;
        @(negedge clk);
        chk("lp_run", 32'(run_a), 1);
        chk("lp_sx", 32'(sx_a), 0);
        chk("lp_fs", 32'(fs_a), 1);

        // Asynchronous reset mid-frame.
        wait_pos(10, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sx", 32'(sx_a), 0);
        chk("arst_sy", 32'(sy_a), 0);
        chk("arst_run", 32'(run_a), 0);
        chk("arst_de_a", 32'(de_a), 0);
        chk("arst_hs_b", 32'(hs_b), 1);
        chk("arst_fc", 32'(fc_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_fs", 32'(fs_a), 1);
        chk("restart_sx", 32'(sx_a), 0);

        // Randomized run/stop requests with occasional reset pulses.
        for (int k = 0; k < 5000; k++) begin
            if ($urandom_range(0, 29) == 0) en = ~en;
            if ($urandom_range(0, 1999) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
